// File: rtl/hvsync_decoder_if.sv
// Sync and regenerated-timing bundle between a sync source and hvsync_decoder.
// master drives the syncs and observes timing; slave is the decoder side.
interface hvsync_decoder_if;
  logic       hsync;
  logic       vsync;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       frame_start;
  logic       locked;
  logic [9:0] h_measured;
  logic [9:0] v_measured;

  modport master (
    output hsync, vsync,
    input  hpos, vpos, display_on, frame_start, locked, h_measured, v_measured
  );

  modport slave (
    input  hsync, vsync,
    output hpos, vpos, display_on, frame_start, locked, h_measured, v_measured
  );
endinterface

// File: rtl/hvsync_decoder.sv
// Sync-timing receiver: measures line/frame periods, locks to a fixed raster and
// regenerates hpos/vpos/display_on aligned to the incoming hsync/vsync.
module hvsync_decoder #(
  parameter int unsigned H_DISPLAY    = 640,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned V_DISPLAY    = 480,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned SYNC_NEG     = 1,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic            clk,
  input  logic            reset,
  hvsync_decoder_if.slave vid
);

  localparam logic [9:0] HDisp      = 10'(H_DISPLAY);
  localparam logic [9:0] HTot       = 10'(H_TOTAL);
  localparam logic [9:0] HSyncStart = 10'(H_SYNC_START);
  localparam logic [9:0] VDisp      = 10'(V_DISPLAY);
  localparam logic [9:0] VTot       = 10'(V_TOTAL);
  localparam logic [9:0] VSyncStart = 10'(V_SYNC_START);
  localparam logic [9:0] CntMax     = 10'h3ff;
  localparam logic [3:0] LockCnt    = 4'(LOCK_FRAMES);
  localparam logic       SyncInv    = (SYNC_NEG != 0);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  state_e     state_q, state_d;
  logic       hs_s_q, hs_p_q, vs_s_q, vs_p_q;
  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [9:0] lc_q, lc_d;
  logic [9:0] vc_q, vc_d;
  logic [9:0] h_meas_q, h_meas_d;
  logic [9:0] v_meas_q, v_meas_d;
  logic       frame_bad_q, frame_bad_d;
  logic       first_q, first_d;
  logic [3:0] good_q, good_d;
  logic       locked_q, locked_d;
  logic       display_on_q, display_on_d;
  logic       frame_start_q, frame_start_d;

  logic       hs_act, vs_act;
  logic       hs_edge, vs_edge;
  logic       h_wrap;
  logic       lc_sat;
  logic       line_bad;
  logic       frame_bad_eff;
  logic       frame_good;
  logic [9:0] vc_eff;
  logic [3:0] good_inc;

  // Normalise to active-high before sampling.
  assign hs_act  = vid.hsync ^ SyncInv;
  assign vs_act  = vid.vsync ^ SyncInv;
  assign hs_edge = hs_s_q & ~hs_p_q;
  assign vs_edge = vs_s_q & ~vs_p_q;

  assign h_wrap   = (hpos_q == HTot - 10'd1);
  assign lc_sat   = (lc_q == CntMax);
  // The interval ending at the first hsync edge after (re)search entry is unknown.
  assign line_bad = hs_edge & ~first_q & (lc_q != HTot);

  // An hsync edge coincident with vsync belongs to the closing frame.
  assign vc_eff        = (hs_edge && vc_q != CntMax) ? vc_q + 10'd1 : vc_q;
  assign frame_bad_eff = frame_bad_q | line_bad | lc_sat;
  assign frame_good    = ~frame_bad_eff & (vc_eff == VTot);
  assign good_inc      = good_q + 4'd1;

  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (hs_edge) begin
      hpos_d = HSyncStart;
    end else if (h_wrap) begin
      hpos_d = '0;
    end else begin
      hpos_d = hpos_q + 10'd1;
    end
    if (vs_edge) begin
      vpos_d = VSyncStart;
    end else if (!hs_edge && h_wrap) begin
      vpos_d = (vpos_q == VTot - 10'd1) ? 10'd0 : vpos_q + 10'd1;
    end
  end

  always_comb begin
    lc_d        = lc_q;
    h_meas_d    = h_meas_q;
    vc_d        = vc_eff;
    v_meas_d    = v_meas_q;
    frame_bad_d = frame_bad_eff;
    if (hs_edge) begin
      lc_d     = 10'd1;
      h_meas_d = lc_q;
    end else if (lc_sat) begin
      h_meas_d = CntMax;
    end else begin
      lc_d = lc_q + 10'd1;
    end
    if (vs_edge) begin
      v_meas_d    = vc_eff;
      vc_d        = '0;
      frame_bad_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      StSearch: begin
        good_d = '0;
        if (vs_edge) begin
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        if (lc_sat) begin
          state_d = StSearch;
          good_d  = '0;
        end else if (vs_edge) begin
          if (frame_good) begin
            good_d = good_inc;
            if (good_inc >= LockCnt) begin
              state_d = StLocked;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      StLocked: begin
        if (line_bad || lc_sat || (vs_edge && !frame_good)) begin
          state_d = StSearch;
          good_d  = '0;
        end
      end
      default: begin
        state_d = StSearch;
        good_d  = '0;
      end
    endcase
  end

  always_comb begin
    first_d = first_q;
    if (hs_edge) begin
      first_d = 1'b0;
    end
    if (state_d == StSearch && state_q != StSearch) begin
      first_d = 1'b1;
    end
  end

  // Registered from next-state values so they line up with hpos/vpos.
  always_comb begin
    locked_d      = (state_d == StLocked);
    display_on_d  = locked_d && (hpos_d < HDisp) && (vpos_d < VDisp);
    frame_start_d = locked_d && (hpos_d == 10'd0) && (vpos_d == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StSearch;
      hs_s_q        <= 1'b0;
      hs_p_q        <= 1'b0;
      vs_s_q        <= 1'b0;
      vs_p_q        <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      lc_q          <= '0;
      vc_q          <= '0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      frame_bad_q   <= 1'b0;
      first_q       <= 1'b1;
      good_q        <= '0;
      locked_q      <= 1'b0;
      display_on_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_s_q        <= hs_act;
      hs_p_q        <= hs_s_q;
      vs_s_q        <= vs_act;
      vs_p_q        <= vs_s_q;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      lc_q          <= lc_d;
      vc_q          <= vc_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      frame_bad_q   <= frame_bad_d;
      first_q       <= first_d;
      good_q        <= good_d;
      locked_q      <= locked_d;
      display_on_q  <= display_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.hpos        = hpos_q;
  assign vid.vpos        = vpos_q;
  assign vid.display_on  = display_on_q;
  assign vid.frame_start = frame_start_q;
  assign vid.locked      = locked_q;
  assign vid.h_measured  = h_meas_q;
  assign vid.v_measured  = v_meas_q;

endmodule

// File: tb/tb_hvsync_decoder.sv
// Bench for hvsync_decoder on a reduced raster: a bench-side sync generator drives an
// active-low and an active-high decoder; generator positions are queued and compared later.
module tb_hvsync_decoder;

  localparam int HD  = 32;
  localparam int HT  = 40;
  localparam int HSS = 33;
  localparam int HSE = 36;
  localparam int VD  = 16;
  localparam int VT  = 20;
  localparam int VSS = 17;
  localparam int VSE = 18;
  localparam int LF  = 2;

  logic clk;
  logic reset;

  hvsync_decoder_if bus_n ();
  hvsync_decoder_if bus_p ();

  hvsync_decoder #(
    .H_DISPLAY(HD), .H_TOTAL(HT), .H_SYNC_START(HSS),
    .V_DISPLAY(VD), .V_TOTAL(VT), .V_SYNC_START(VSS),
    .SYNC_NEG(1), .LOCK_FRAMES(LF)
  ) dut_n (
    .clk  (clk),
    .reset(reset),
    .vid  (bus_n.slave)
  );

  hvsync_decoder #(
    .H_DISPLAY(HD), .H_TOTAL(HT), .H_SYNC_START(HSS),
    .V_DISPLAY(VD), .V_TOTAL(VT), .V_SYNC_START(VSS),
    .SYNC_NEG(0), .LOCK_FRAMES(LF)
  ) dut_p (
    .clk  (clk),
    .reset(reset),
    .vid  (bus_p.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int h; int v; } pos_t;
  pos_t sbq[$];

  int n_checks = 0;
  int n_errors = 0;
  int gh = 0, gv = 0;
  bit gen_en = 0, gen_hoff = 0, gen_stall = 0, short_frame = 0, chk_pos = 0;
  bit hs_act = 0, vs_act = 0, hs_prev = 0, vs_prev = 0;
  int hs_events = 0, vs_events = 0, fs_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_sync();
    hs_act = gen_en && !gen_hoff && gh >= HSS && gh <= HSE;
    vs_act = gen_en && gv >= VSS && gv <= VSE;
    if (hs_act && !hs_prev) hs_events++;
    if (vs_act && !vs_prev) vs_events++;
    hs_prev = hs_act;
    vs_prev = vs_act;
    bus_n.hsync = ~hs_act;
    bus_n.vsync = ~vs_act;
    bus_p.hsync = hs_act;
    bus_p.vsync = vs_act;
  endtask

  // One clock: sample the DUTs for this cycle, then drive this cycle's generator state.
  task automatic tick();
    pos_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 2) begin
      e = sbq.pop_front();
      if (chk_pos) begin
        check_eq("hpos_n", 32'(bus_n.hpos), e.h);
        check_eq("vpos_n", 32'(bus_n.vpos), e.v);
        check_eq("hpos_p", 32'(bus_p.hpos), e.h);
        check_eq("vpos_p", 32'(bus_p.vpos), e.v);
        check_eq("locked_n", 32'(bus_n.locked), 1);
        check_eq("display_on_n", 32'(bus_n.display_on), 32'(e.h < HD && e.v < VD));
        check_eq("frame_start_n", 32'(bus_n.frame_start), 32'(e.h == 0 && e.v == 0));
        if (bus_n.frame_start) fs_cnt++;
      end
    end
    if (gen_en && !gen_stall) begin
      if (gh == HT - 1) begin
        gh = 0;
        if (gv == (short_frame ? VT - 2 : VT - 1)) begin
          gv = 0;
          short_frame = 0;
        end else begin
          gv++;
        end
      end else begin
        gh++;
      end
    end
    gen_stall = 0;
    drive_sync();
    sbq.push_back('{h: gh, v: gv});
  endtask

  task automatic run_until_vs(input int n);
    int target = vs_events + n;
    int lim = n * HT * VT * 2 + 100;
    while (vs_events < target && lim > 0) begin
      tick();
      lim--;
    end
    check_eq("vs_wait", vs_events, target);
  endtask

  task automatic run_until_hs(input int n);
    int target = hs_events + n;
    int lim = n * HT * 2 + 100;
    while (hs_events < target && lim > 0) begin
      tick();
      lim--;
    end
    check_eq("hs_wait", hs_events, target);
  endtask

  task automatic run_until_pos(input int h, input int v);
    int lim = HT * VT * 2 + 100;
    while (!(gh == h && (v < 0 || gv == v)) && lim > 0) begin
      tick();
      lim--;
    end
    check_eq("pos_wait", gh, h);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_hpos", 32'(bus_n.hpos), 0);
    check_eq("rst_vpos", 32'(bus_n.vpos), 0);
    check_eq("rst_display_on", 32'(bus_n.display_on), 0);
    check_eq("rst_frame_start", 32'(bus_n.frame_start), 0);
    check_eq("rst_locked", 32'(bus_n.locked), 0);
    check_eq("rst_h_measured", 32'(bus_n.h_measured), 0);
    check_eq("rst_v_measured", 32'(bus_n.v_measured), 0);
    check_eq("rst_locked_p", 32'(bus_p.locked), 0);
  endtask

  task automatic check_lock_seq(input string tag);
    run_until_vs(LF + 1);
    tick();
    check_eq({tag, "_locked_early_n"}, 32'(bus_n.locked), 0);
    check_eq({tag, "_locked_early_p"}, 32'(bus_p.locked), 0);
    tick();
    check_eq({tag, "_locked_n"}, 32'(bus_n.locked), 1);
    check_eq({tag, "_locked_p"}, 32'(bus_p.locked), 1);
    check_eq({tag, "_h_meas_n"}, 32'(bus_n.h_measured), HT);
    check_eq({tag, "_v_meas_n"}, 32'(bus_n.v_measured), VT);
    check_eq({tag, "_h_meas_p"}, 32'(bus_p.h_measured), HT);
    check_eq({tag, "_v_meas_p"}, 32'(bus_p.v_measured), VT);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive_sync();
    repeat (10) tick();
    check_reset_vals();

    // Lock from reset: one search frame plus LF good frames.
    reset = 1'b0;
    gen_en = 1;
    check_lock_seq("t1");

    // Regenerated positions track the generator for a full frame.
    fs_cnt = 0;
    chk_pos = 1;
    repeat (HT * VT) tick();
    chk_pos = 0;
    check_eq("frame_start_count", fs_cnt, 1);

    // One 41-clock line drops lock right after its hsync edge.
    run_until_pos(5, -1);
    gen_stall = 1;
    run_until_hs(1);
    tick();
    check_eq("t3_locked_at_edge", 32'(bus_n.locked), 1);
    tick();
    check_eq("t3_locked_drop", 32'(bus_n.locked), 0);
    check_eq("t3_h_meas_long", 32'(bus_n.h_measured), HT + 1);
    check_lock_seq("t3_relock");

    // Lost hsync: line counter saturates.
    gen_hoff = 1;
    repeat (1100) tick();
    check_eq("t4_h_meas_sat", 32'(bus_n.h_measured), 1023);
    check_eq("t4_locked", 32'(bus_n.locked), 0);
    check_eq("t4_display_on", 32'(bus_n.display_on), 0);
    check_eq("t4_h_meas_sat_p", 32'(bus_p.h_measured), 1023);

    // Short frame resets the good-frame count.
    run_until_pos(0, 0);
    gen_hoff = 0;
    run_until_vs(2);
    short_frame = 1;
    run_until_vs(1);
    tick();
    tick();
    check_eq("t5_locked_short", 32'(bus_n.locked), 0);
    check_eq("t5_v_meas_short", 32'(bus_n.v_measured), VT - 1);
    run_until_vs(1);
    tick();
    tick();
    check_eq("t5_locked_one_good", 32'(bus_n.locked), 0);
    run_until_vs(1);
    tick();
    check_eq("t5_locked_early", 32'(bus_n.locked), 0);
    tick();
    check_eq("t5_relocked", 32'(bus_n.locked), 1);
    check_eq("t5_v_meas", 32'(bus_n.v_measured), VT);

    // Reset mid-line while locked, then relock from the middle of a frame.
    run_until_pos(10, 5);
    check_eq("t6_locked_before", 32'(bus_n.locked), 1);
    reset = 1'b1;
    tick();
    check_reset_vals();
    repeat (9) tick();
    reset = 1'b0;
    check_lock_seq("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
